// File: rtl/demux_pkg.sv
// Shared definitions for the 1x2 packet dispatcher: FSM state encoding and
// the destination-selection mode constants.
package demux_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_e;

   localparam logic MODE_RR   = 1'b0;
   localparam logic MODE_DEST = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered output slot: holds a single beat until the consumer
// takes it, and can be refilled in the same cycle it drains.
module demux_out_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             last_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             last_o,
   output logic             can_accept_o
);

   logic             valid_q;
   logic [WIDTH-1:0] data_q;
   logic             last_q;

   // A load wins over a drain so simultaneous load/drain keeps the slot full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         last_q  <= last_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o      = valid_q;
   assign data_o       = data_q;
   assign last_o       = last_q;
   assign can_accept_o = ~valid_q | ready_i;

endmodule

// File: rtl/demux_1x2_dispatcher.sv
// Routes one valid/ready packet stream to one of two output slots, holding the
// destination for the whole packet; sel drives the downstream demux select.
module demux_1x2_dispatcher
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   input  logic             in_dest,
   output logic             in_ready,
   input  logic             mode,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   output logic             out0_last,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   output logic             out1_last,
   input  logic             out1_ready,
   output logic             sel,
   output logic [7:0]       pkt_cnt0,
   output logic [7:0]       pkt_cnt1
);

   state_e     state_q, state_d;
   logic       rr_q, rr_d;
   logic       sel_q, sel_d;
   logic [7:0] pktCnt0_q, pktCnt0_d;
   logic [7:0] pktCnt1_q, pktCnt1_d;

   logic canAccept0, canAccept1;
   logic target, route, routeCanAccept, accept;
   logic load0, load1;

   demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
      .clk          (clk),
      .rst          (rst),
      .load_i       (load0),
      .data_i       (in_data),
      .last_i       (in_last),
      .ready_i      (out0_ready),
      .valid_o      (out0_valid),
      .data_o       (out0_data),
      .last_o       (out0_last),
      .can_accept_o (canAccept0)
   );

   demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
      .clk          (clk),
      .rst          (rst),
      .load_i       (load1),
      .data_i       (in_data),
      .last_i       (in_last),
      .ready_i      (out1_ready),
      .valid_o      (out1_valid),
      .data_o       (out1_data),
      .last_o       (out1_last),
      .can_accept_o (canAccept1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_q      <= 1'b0;
         sel_q     <= 1'b0;
         pktCnt0_q <= 8'd0;
         pktCnt1_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         sel_q     <= sel_d;
         pktCnt0_q <= pktCnt0_d;
         pktCnt1_q <= pktCnt1_d;
      end
   end

   // Round-robin falls over to the other slot when the preferred one is
   // blocked, so a stalled consumer never idles the input.
   always_comb begin
      target = (mode == MODE_DEST) ? in_dest : rr_q;
      if (mode == MODE_RR) begin
         if (!rr_q && !canAccept0 && canAccept1) begin
            target = 1'b1;
         end else if (rr_q && !canAccept1 && canAccept0) begin
            target = 1'b0;
         end
      end

      case (state_q)
         LOCK0:   route = 1'b0;
         LOCK1:   route = 1'b1;
         default: route = target;
      endcase

      routeCanAccept = route ? canAccept1 : canAccept0;
      accept         = in_valid & routeCanAccept;
      load0          = accept & ~route;
      load1          = accept & route;

      state_d   = state_q;
      rr_d      = rr_q;
      sel_d     = sel_q;
      pktCnt0_d = pktCnt0_q;
      pktCnt1_d = pktCnt1_q;

      if (accept) begin
         sel_d = route;
         if (in_last) begin
            state_d = IDLE;
            rr_d    = ~route;
            if (route) begin
               pktCnt1_d = pktCnt1_q + 8'd1;
            end else begin
               pktCnt0_d = pktCnt0_q + 8'd1;
            end
         end else if (state_q == IDLE) begin
            state_d = route ? LOCK1 : LOCK0;
         end
      end
   end

   assign in_ready = accept;
   assign sel      = sel_q;
   assign pkt_cnt0 = pktCnt0_q;
   assign pkt_cnt1 = pktCnt1_q;

endmodule

// File: tb/tb_demux_1x2_dispatcher.sv
// Directed self-checking bench for demux_1x2_dispatcher: one task per scenario,
// each with hand-computed expectations.
module tb_demux_1x2_dispatcher;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'd0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_dest = 1'b0;
   logic       in_ready;
   logic       mode = 1'b0;
   logic [7:0] out0_data, out1_data;
   logic       out0_valid, out1_valid;
   logic       out0_last, out1_last;
   logic       out0_ready = 1'b0;
   logic       out1_ready = 1'b0;
   logic       sel;
   logic [7:0] pkt_cnt0, pkt_cnt1;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   demux_1x2_dispatcher #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_dest    (in_dest),
      .in_ready   (in_ready),
      .mode       (mode),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_last  (out0_last),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_last  (out1_last),
      .out1_ready (out1_ready),
      .sel        (sel),
      .pkt_cnt0   (pkt_cnt0),
      .pkt_cnt1   (pkt_cnt1)
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut;
      in_valid   = 1'b0;
      in_data    = 8'd0;
      in_last    = 1'b0;
      in_dest    = 1'b0;
      mode       = 1'b0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      tick();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      resetDut();
      total++;
      if ({out0_valid, out1_valid, out0_data, out1_data, out0_last, out1_last,
           sel, in_ready} !== 20'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%0h exp=0",
                  {out0_valid, out1_valid, out0_data, out1_data, out0_last, out1_last, sel, in_ready});
      end
      total++;
      if ({pkt_cnt0, pkt_cnt1} !== 16'd0) begin
         bad++;
         $display("[TB] FAIL reset_counters got=%0h exp=0", {pkt_cnt0, pkt_cnt1});
      end
   endtask

   task automatic test_round_robin;
      logic [7:0] dataTab [6] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1};
      logic       portTab [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      resetDut();
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = dataTab[i];
         in_last  = (i % 2) == 1;
         #1;
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rr_in_ready beat=%0d got=%b exp=1", i, in_ready);
         end
         tick();
         total++;
         if (portTab[i] == 1'b0) begin
            if ({out0_valid, out0_data, out0_last, sel} !== {1'b1, dataTab[i], in_last, 1'b0}) begin
               bad++;
               $display("[TB] FAIL rr_out0 beat=%0d got=%0h exp=%0h", i,
                        {out0_valid, out0_data, out0_last, sel}, {1'b1, dataTab[i], in_last, 1'b0});
            end
         end else begin
            if ({out1_valid, out1_data, out1_last, sel} !== {1'b1, dataTab[i], in_last, 1'b1}) begin
               bad++;
               $display("[TB] FAIL rr_out1 beat=%0d got=%0h exp=%0h", i,
                        {out1_valid, out1_data, out1_last, sel}, {1'b1, dataTab[i], in_last, 1'b1});
            end
         end
      end
      in_valid = 1'b0;
      tick();
      total++;
      if ({pkt_cnt0, pkt_cnt1} !== {8'd2, 8'd1}) begin
         bad++;
         $display("[TB] FAIL rr_counts got=%0d/%0d exp=2/1", pkt_cnt0, pkt_cnt1);
      end
   endtask

   task automatic test_dest_mode;
      resetDut();
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = 8'h40 + 8'(k);
         in_last  = (k == 3);
         mode     = (k == 0);
         in_dest  = (k == 0) ? 1'b1 : k[0];
         tick();
         total++;
         if ({out1_valid, out1_data, out0_valid} !== {1'b1, 8'h40 + 8'(k), 1'b0}) begin
            bad++;
            $display("[TB] FAIL dest_beat k=%0d got=%0h exp=%0h", k,
                     {out1_valid, out1_data, out0_valid}, {1'b1, 8'h40 + 8'(k), 1'b0});
         end
      end
      in_valid = 1'b0;
      tick();
      total++;
      if ({pkt_cnt0, pkt_cnt1} !== {8'd0, 8'd1}) begin
         bad++;
         $display("[TB] FAIL dest_counts got=%0d/%0d exp=0/1", pkt_cnt0, pkt_cnt1);
      end
      // rr must now point at out0
      mode     = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h4F;
      in_last  = 1'b1;
      tick();
      in_valid = 1'b0;
      total++;
      if ({out0_valid, out0_data, sel, pkt_cnt0} !== {1'b1, 8'h4F, 1'b0, 8'd1}) begin
         bad++;
         $display("[TB] FAIL dest_rr_after got=%0h exp=%0h",
                  {out0_valid, out0_data, sel, pkt_cnt0}, {1'b1, 8'h4F, 1'b0, 8'd1});
      end
   endtask

   task automatic test_backpressure;
      resetDut();
      out0_ready = 1'b0;
      out1_ready = 1'b1;
      in_valid   = 1'b1;
      in_data    = 8'h50;
      in_last    = 1'b0;
      tick();
      in_data = 8'h51;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bp_stall_ready got=%b exp=0", in_ready);
      end
      tick();
      total++;
      if ({out0_valid, out0_data, out1_valid} !== {1'b1, 8'h50, 1'b0}) begin
         bad++;
         $display("[TB] FAIL bp_hold got=%0h exp=%0h", {out0_valid, out0_data, out1_valid},
                  {1'b1, 8'h50, 1'b0});
      end
      out0_ready = 1'b1;
      for (int k = 1; k < 3; k++) begin
         in_data = 8'h50 + 8'(k);
         in_last = (k == 2);
         #1;
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_resume_ready k=%0d got=%b exp=1", k, in_ready);
         end
         tick();
         total++;
         if ({out0_valid, out0_data, out0_last} !== {1'b1, 8'h50 + 8'(k), k == 2}) begin
            bad++;
            $display("[TB] FAIL bp_resume_data k=%0d got=%0h exp=%0h", k,
                     {out0_valid, out0_data, out0_last}, {1'b1, 8'h50 + 8'(k), k == 2});
         end
      end
      in_valid = 1'b0;
      total++;
      if (pkt_cnt0 !== 8'd1) begin
         bad++;
         $display("[TB] FAIL bp_count got=%0d exp=1", pkt_cnt0);
      end
   endtask

   task automatic test_work_conserving;
      resetDut();
      out0_ready = 1'b0;
      out1_ready = 1'b1;
      in_valid   = 1'b1;
      in_last    = 1'b1;
      mode       = 1'b1;
      in_dest    = 1'b0;
      in_data    = 8'h60;
      tick();
      in_dest = 1'b1;
      in_data = 8'h61;
      tick();
      mode    = 1'b0;
      in_data = 8'h62;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL wc_in_ready got=%b exp=1", in_ready);
      end
      tick();
      total++;
      if ({out1_valid, out1_data, sel, out0_data, pkt_cnt1} !== {1'b1, 8'h62, 1'b1, 8'h60, 8'd2}) begin
         bad++;
         $display("[TB] FAIL wc_route got=%0h exp=%0h", {out1_valid, out1_data, sel, out0_data, pkt_cnt1},
                  {1'b1, 8'h62, 1'b1, 8'h60, 8'd2});
      end
      out0_ready = 1'b1;
      in_data    = 8'h63;
      tick();
      in_valid = 1'b0;
      total++;
      if ({out0_valid, out0_data, sel, pkt_cnt0} !== {1'b1, 8'h63, 1'b0, 8'd2}) begin
         bad++;
         $display("[TB] FAIL wc_rr_after got=%0h exp=%0h", {out0_valid, out0_data, sel, pkt_cnt0},
                  {1'b1, 8'h63, 1'b0, 8'd2});
      end
   endtask

   task automatic test_async_reset;
      resetDut();
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      in_valid   = 1'b1;
      in_data    = 8'h70;
      in_last    = 1'b0;
      tick();
      in_data = 8'h71;
      #1;
      rst = 1'b1;
      #1;
      total++;
      if ({out0_valid, out1_valid, out0_data, out1_data, out0_last, out1_last, sel,
           pkt_cnt0, pkt_cnt1} !== 37'd0) begin
         bad++;
         $display("[TB] FAIL arst_clear got=%0h exp=0", {out0_valid, out1_valid, out0_data, out1_data,
                  out0_last, out1_last, sel, pkt_cnt0, pkt_cnt1});
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      in_valid = 1'b1;
      in_data  = 8'h7E;
      in_last  = 1'b1;
      tick();
      total++;
      if ({out0_valid, out0_data, sel, pkt_cnt0} !== {1'b1, 8'h7E, 1'b0, 8'd1}) begin
         bad++;
         $display("[TB] FAIL arst_next_out0 got=%0h exp=%0h", {out0_valid, out0_data, sel, pkt_cnt0},
                  {1'b1, 8'h7E, 1'b0, 8'd1});
      end
      mode    = 1'b1;
      in_dest = 1'b1;
      in_data = 8'h7F;
      tick();
      in_valid = 1'b0;
      total++;
      if ({out1_valid, out1_data, sel, pkt_cnt1} !== {1'b1, 8'h7F, 1'b1, 8'd1}) begin
         bad++;
         $display("[TB] FAIL arst_idle_dest got=%0h exp=%0h", {out1_valid, out1_data, sel, pkt_cnt1},
                  {1'b1, 8'h7F, 1'b1, 8'd1});
      end
   endtask

   task automatic test_counter_wrap;
      resetDut();
      out0_ready = 1'b1;
      mode       = 1'b1;
      in_dest    = 1'b0;
      in_last    = 1'b1;
      in_valid   = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_data = 8'(i);
         #1;
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wrap_in_ready i=%0d got=%b exp=1", i, in_ready);
         end
         tick();
         if (i == 254) begin
            total++;
            if (pkt_cnt0 !== 8'd255) begin
               bad++;
               $display("[TB] FAIL wrap_at_255 got=%0d exp=255", pkt_cnt0);
            end
         end
      end
      in_valid = 1'b0;
      total++;
      if ({pkt_cnt0, pkt_cnt1} !== 16'd0) begin
         bad++;
         $display("[TB] FAIL wrap_to_zero got=%0d/%0d exp=0/0", pkt_cnt0, pkt_cnt1);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_dest_mode();
      test_backpressure();
      test_work_conserving();
      test_async_reset();
      test_counter_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux_1x2_dispatcher.md
# demux_1x2_dispatcher

Packet dispatcher that routes a single valid/ready input stream to one of two output streams, and so sequences the 1-to-2 demultiplexer datapath. The destination is chosen per packet, by work-conserving round-robin or by an explicit destination bit, and is held until the packet's last beat. Each output has a one-entry registered slot for full-throughput pass-through. The `sel` output drives the select input of the 1x2 demux.

## Interface
- `WIDTH`, default 8: data beat width in bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  input beat.
- `in_valid`  in  1  input beat present.
- `in_last`  in  1  beat is the final beat of its packet.
- `in_dest`  in  1  requested output; used only when `mode`=1.
- `in_ready`  out  1  beat accepted this cycle when `in_valid` & `in_ready`.
- `mode`  in  1  0 = round-robin, 1 = explicit `in_dest`.
- `out0_data`/`out1_data`  out  WIDTH  output slot data.
- `out0_valid`/`out1_valid`  out  1  slot occupied.
- `out0_last`/`out1_last`  out  1  slot holds a last beat.
- `out0_ready`/`out1_ready`  in  1  consumer takes the slot beat.
- `sel`  out  1  currently or most recently granted output; drives the demux select.
- `pkt_cnt0`/`pkt_cnt1`  out  8  completed packets per output; wraps from 255 to 0.

Reset values: all outputs 0, FSM state IDLE, round-robin pointer `rr` = 0.

## Operation
- FSM states:
  - IDLE: no packet in progress.
  - LOCK0 / LOCK1: packet routed to out0 / out1.
- Target selection in IDLE is combinational, evaluated while `in_valid`=1:
  - `mode`=1: target = `in_dest`.
  - `mode`=0: target = `rr`. If the `rr` slot cannot accept and the other slot can, target = the other output.
- Slot x can accept when `outx_valid`=0 or `outx_ready`=1.
- `in_ready`:
  - IDLE: true when the target slot can accept.
  - LOCKx: true when slot x can accept. The other slot is ignored.
- Accepted beat:
  - Loads slot x with data and last, sets `outx_valid`=1, and sets `sel`=x.
- Transitions on an accepted beat:
  - In IDLE: beat with `in_last`=0 goes to LOCKx. Beat with `in_last`=1 (single-beat packet) stays in IDLE.
  - In LOCKx: beat with `in_last`=1 goes to IDLE.
- Packet end (accepted beat with `in_last`=1):
  - `pkt_cnt`x increments.
  - `rr` becomes ~x in both modes.
- Slot drain: `outx_valid` clears when `outx_ready`=1 and no new beat loads that cycle. Load and drain in the same cycle keeps `outx_valid`=1 with the new data.
- `mode` and `in_dest` are sampled only on the first beat of a packet. Changes mid-packet have no effect.
- `in_valid`=0 causes no state change. `in_data`, `in_last` and `in_dest` are don't-care.
- Asserting `rst` mid-packet clears the slots, counters, FSM and `rr` immediately. The partial packet is dropped, with no recovery.

## Timing
- Input-to-output latency: 1 cycle. A beat accepted at edge N appears on `outx_*` after edge N.
- Throughput: 1 beat/cycle per stream when the consumer holds ready high.
- `in_ready` depends combinationally on `outx_ready`, `in_valid`, `mode`, `in_dest` and state. There is no combinational path from `in_valid` to `outx_valid`.
- Back-to-back packets: a new packet may start in the cycle after the last beat, and may target the other output.
- `sel` changes in the same cycle as the first beat is loaded.

## Structure
- Shared package `demux_pkg`:
  - State encoding IDLE/LOCK0/LOCK1.
  - Mode constants MODE_RR=0, MODE_DEST=1.
- Sub-module `demux_out_slot`: one-entry register slot, instantiated twice.
  - Inputs: `load`, `data`, `last`, `ready`.
  - Outputs: `valid`, `data`, `last`, `can_accept`.
- Top level holds the FSM, target selection, `rr`, the counters, and `sel`.

## Test plan
- Round-robin, both ready, three 2-beat packets A/B/C: A goes to out0, B to out1, C to out0. `pkt_cnt0`=2, `pkt_cnt1`=1, no idle cycles.
- `mode`=1, `in_dest`=1, 4-beat packet; `in_dest` toggled and `mode` set to 0 mid-packet: all 4 beats on out1, `pkt_cnt1`=1, then `rr`=0.
- Backpressure: `out0_ready`=0 during a LOCK0 packet. After 1 beat fills the slot, `in_ready`=0 even with out1 empty. Releasing `out0_ready` resumes at 1 beat/cycle.
- Work-conserving: `rr`=0, out0 slot full with `out0_ready`=0, single-beat packet arrives. It routes to out1, `sel`=1, `rr` becomes 0.
- Async `rst` pulse mid-cycle during beat 2 of a 3-beat packet: all outputs 0 immediately, state IDLE. The next packet goes to out0.
- Counter wrap: 256 single-beat packets in `mode`=1 with `in_dest`=0 leave `pkt_cnt0` back at 0.
